fir_tap_sequencer: RTL and testbench
====================================

# fir_tap_sequencer

Drives one `FIR_Tap` multiply-accumulate tap as a time-multiplexed N-tap FIR filter. On each new audio sample the block:
- stores the sample in a circular history buffer,
- clears the tap,
- streams coefficient/sample pairs newest-to-oldest,
- drains the tap pipeline,
- captures and saturates the accumulator as a 24-bit result.

It also owns the coefficient RAM and its write port.

## Interface
- `NUM_TAPS`, 64: filter length, power of two, 2–256.
- `PIPE_LATENCY`, 7: cycles from `tap_en`-qualified input to its effect on `tap_acc` (multiply + accumulate).
- `RESULT_SHIFT`, 7: arithmetic right shift applied to `tap_acc` before saturation.
- `clk` in 1: the block's single clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `sample_stb` in 1: one-cycle pulse, `sample_in` valid.
- `sample_in` in 24: signed sample.
- `coef_wr_en` in 1: coefficient write strobe.
- `coef_wr_addr` in log2(`NUM_TAPS`): coefficient index k (k=0 multiplies newest sample).
- `coef_wr_data` in 16: signed Q1.15 coefficient.
- `coef_wr_rej` out 1: one-cycle pulse, write dropped because busy.
- `tap_clr` out 1: to tap `data_valid_stb`.
- `tap_en` out 1: to tap `fir_en`.
- `tap_coef` out 16: to tap `coefficients`.
- `tap_data` out 24: to tap `data_in`.
- `tap_acc` in 48: from tap `data_out`.
- `result_out` out 24: signed filtered sample, held until next result.
- `result_valid` out 1: one-cycle pulse.
- `busy` out 1: high in every state except IDLE.
- `overrun` out 1: sticky; a `sample_stb` arrived while busy.

## Operation
- States and transitions:
  - IDLE → CLEAR on `sample_stb`.
  - CLEAR (1 cycle) → RUN.
  - RUN (`NUM_TAPS` cycles) → DRAIN.
  - DRAIN (`PIPE_LATENCY` cycles) → CAPTURE.
  - CAPTURE (1 cycle) → IDLE.
- CLEAR:
  - `tap_clr`=1, `tap_en`=0.
  - Sample written at write pointer; pointer increments, wrapping modulo `NUM_TAPS`.
  - Fill count increments, saturating at `NUM_TAPS`.
- RUN cycle k: `tap_en`=1, `tap_coef`=c[k], `tap_data`=history[newest−k].
  - `tap_data` is forced to 0 when k ≥ fill count, so unwritten history contributes nothing.
- DRAIN: `tap_en`=1, `tap_coef`=0, `tap_data`=0.
- CAPTURE: `result_out` = saturate24(`tap_acc` >>> `RESULT_SHIFT`), clamped to [−2^23, 2^23−1].
  - Net scaling: Σ x·c / 2^15, with per-product truncation inherited from the tap.
- Outside RUN/DRAIN: `tap_en`=0, `tap_coef`=0, `tap_data`=0.
- `sample_stb` while busy:
  - Sample is dropped and history is untouched.
  - `overrun`←1; it clears only on reset.
- `coef_wr_en` while idle: write takes effect next cycle.
- `coef_wr_en` while busy: write is dropped and `coef_wr_rej` pulses the following cycle.
- `sample_stb` and `coef_wr_en` in the same idle cycle: the write is accepted and the sample is accepted.
  - The computation uses the new coefficient only if its index is read after the write. Write ordering guarantees this, since the first read occurs in RUN.

## Timing
- `sample_stb` sampled at cycle 0.
- CLEAR at cycle 1.
- RUN cycles 2..`NUM_TAPS`+1.
- CAPTURE at cycle `NUM_TAPS`+`PIPE_LATENCY`+2.
- `result_valid` at cycle `NUM_TAPS`+`PIPE_LATENCY`+3 (74 with defaults).
- Next `sample_stb` is accepted on the cycle `result_valid` is high.
- Tap-facing outputs are registered. History and coefficient RAM reads are synchronous (1 cycle), pipelined so outputs align with the state as listed.
- Reset (asynchronous assert, synchronous deassert handled upstream):
  - state IDLE; all outputs 0.
  - write pointer 0; fill count 0.
  - RAM contents not reset; coefficients are undefined until written.
- Reset mid-computation: abort immediately, no `result_valid`. The next sample sees fill count 0.

## Structure
- Shared package `fir_seq_pkg` holds:
  - state enum (IDLE, CLEAR, RUN, DRAIN, CAPTURE);
  - defaults for `NUM_TAPS`, `PIPE_LATENCY`, `RESULT_SHIFT`;
  - width constants: 24 sample, 16 coef, 48 acc.
- Sub-module `fir_history_ram`: parameterised circular buffer with one write port and one synchronous read port, addressed by pointer arithmetic.
- The coefficient RAM stays inline.

## Test plan
- **Impulse:** c[0]=0x4000, others 0; `sample_stb` with 1000 → `result_out`=500 with `result_valid` exactly 74 cycles after the strobe.
- **Fill/accumulate:** all c=0x2000; samples 4000 then 8000 → results 1000 then 3000.
- **Saturation:** all c=0x7FFF; 64 samples of 0x7FFFFF → final result 0x7FFFFF. Then 64 samples of 0x800000 → final result 0x800000.
- **Overrun:** second `sample_stb` 10 cycles after the first → `overrun`=1, result equals single-sample case, and history is unchanged on the next computation.
- **Busy write:** `coef_wr_en` during RUN → `coef_wr_rej` pulse; readback via impulse shows the old coefficient.
- **Reset mid-RUN:** assert `reset_n`=0 at cycle 20 → all outputs 0 and no `result_valid`. After release, impulse 1000 with c[0]=0x4000 and c[1]=0x4000 → 500 (old history ignored).

Source files
------------

// File: rtl/fir_seq_pkg.sv
// Shared types and constants for the FIR tap sequencer.
package fir_seq_pkg;

  // Default filter geometry
  localparam int NUM_TAPS_DEF     = 64;
  localparam int PIPE_LATENCY_DEF = 7;
  localparam int RESULT_SHIFT_DEF = 7;

  // Datapath widths
  localparam int SAMPLE_W = 24;
  localparam int COEF_W   = 16;
  localparam int ACC_W    = 48;

  // Saturation bounds for the 24-bit result, expressed at accumulator width
  localparam logic signed [ACC_W-1:0] RES_MAX = 48'sd8388607;
  localparam logic signed [ACC_W-1:0] RES_MIN = -48'sd8388608;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_RUN     = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_CAPTURE = 3'd4
  } state_t;

  // Clamp an already-shifted accumulator value into signed 24-bit range
  function automatic logic [SAMPLE_W-1:0] sat_result(input logic signed [ACC_W-1:0] value);
    logic [SAMPLE_W-1:0] res;
    if (value > RES_MAX) begin
      res = 24'h7FFFFF;
    end else if (value < RES_MIN) begin
      res = 24'h800000;
    end else begin
      res = value[SAMPLE_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_history_ram.sv
// Circular sample history: one write port at the write pointer, one
// synchronous read port addressed as "k samples older than the newest".
module fir_history_ram
  import fir_seq_pkg::*;
#(
  parameter int DEPTH = NUM_TAPS_DEF,
  parameter int WIDTH = SAMPLE_W
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_offset,
  output logic [WIDTH-1:0]         rd_data
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_addr_s;

  // Newest sample sits just behind the write pointer; DEPTH is a power of two so wrap is free
  assign rd_addr_s = wr_ptr_r - AW'(1) - rd_offset;

  // Write pointer advances past each stored sample
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {AW{1'b0}};
    end else if (wr_en) begin
      wr_ptr_r <= wr_ptr_r + AW'(1);
    end
  end

  // Storage array, deliberately not reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Registered read; a disabled read returns zero so invalid history contributes nothing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data <= {WIDTH{1'b0}};
    end else if (rd_en) begin
      rd_data <= mem_r[rd_addr_s];
    end else begin
      rd_data <= {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/fir_tap_sequencer.sv
// Time-multiplexes one external MAC tap as an N-tap FIR filter: per sample it
// clears the tap, streams coefficient/history pairs, drains the tap pipeline
// and captures a saturated 24-bit result. Owns the coefficient RAM.
module fir_tap_sequencer
  import fir_seq_pkg::*;
#(
  parameter int NUM_TAPS     = NUM_TAPS_DEF,
  parameter int PIPE_LATENCY = PIPE_LATENCY_DEF,
  parameter int RESULT_SHIFT = RESULT_SHIFT_DEF
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        sample_stb,
  input  logic [SAMPLE_W-1:0]         sample_in,
  input  logic                        coef_wr_en,
  input  logic [$clog2(NUM_TAPS)-1:0] coef_wr_addr,
  input  logic [COEF_W-1:0]           coef_wr_data,
  output logic                        coef_wr_rej,
  output logic                        tap_clr,
  output logic                        tap_en,
  output logic [COEF_W-1:0]           tap_coef,
  output logic [SAMPLE_W-1:0]         tap_data,
  input  logic [ACC_W-1:0]            tap_acc,
  output logic [SAMPLE_W-1:0]         result_out,
  output logic                        result_valid,
  output logic                        busy,
  output logic                        overrun
);

  localparam int TAP_W  = $clog2(NUM_TAPS);
  localparam int FILL_W = TAP_W + 1;
  localparam int CNT_W  = $clog2(NUM_TAPS + PIPE_LATENCY);

  state_t                  state_r;
  state_t                  state_s;
  logic [CNT_W-1:0]        cnt_r;
  logic [CNT_W-1:0]        cnt_s;
  logic [FILL_W-1:0]       fill_r;
  logic [COEF_W-1:0]       coef_mem_r [NUM_TAPS];
  logic [TAP_W-1:0]        rd_k_s;
  logic                    idle_s;
  logic                    accept_s;
  logic                    hist_rd_s;
  logic signed [ACC_W-1:0] acc_shift_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign accept_s    = idle_s & sample_stb;
  // Reads are issued one cycle ahead, so the tap index comes from the next-state counter
  assign rd_k_s      = cnt_s[TAP_W-1:0];
  assign hist_rd_s   = (state_s == ST_RUN) && ({1'b0, rd_k_s} < fill_r);
  assign acc_shift_s = $signed(tap_acc) >>> RESULT_SHIFT;

  // Next-state and phase counter for the clear/run/drain/capture schedule
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        cnt_s = {CNT_W{1'b0}};
        if (sample_stb) begin
          state_s = ST_CLEAR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        state_s = ST_RUN;
        cnt_s   = {CNT_W{1'b0}};
      end
      ST_RUN: begin
        if (cnt_r == CNT_W'(NUM_TAPS - 1)) begin
          state_s = ST_DRAIN;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = ST_RUN;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        if (cnt_r == CNT_W'(PIPE_LATENCY - 1)) begin
          state_s = ST_CAPTURE;
          cnt_s   = {CNT_W{1'b0}};
        end else begin
          state_s = ST_DRAIN;
          cnt_s   = cnt_r + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and phase counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
    end
  end

  // Count of history slots holding real samples, saturating at the filter length
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_r <= {FILL_W{1'b0}};
    end else if (accept_s && (fill_r != FILL_W'(NUM_TAPS))) begin
      fill_r <= fill_r + FILL_W'(1);
    end
  end

  // Coefficient RAM write port, open only while idle
  always_ff @(posedge clk) begin
    if (coef_wr_en && idle_s) begin
      coef_mem_r[coef_wr_addr] <= coef_wr_data;
    end
  end

  // Coefficient RAM synchronous read doubles as the tap_coef output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap_coef <= {COEF_W{1'b0}};
    end else if (state_s == ST_RUN) begin
      tap_coef <= coef_mem_r[rd_k_s];
    end else begin
      tap_coef <= {COEF_W{1'b0}};
    end
  end

  // Registered control, status and result outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tap_clr      <= 1'b0;
      tap_en       <= 1'b0;
      busy         <= 1'b0;
      coef_wr_rej  <= 1'b0;
      result_valid <= 1'b0;
      result_out   <= {SAMPLE_W{1'b0}};
      overrun      <= 1'b0;
    end else begin
      tap_clr      <= (state_s == ST_CLEAR);
      tap_en       <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      busy         <= (state_s != ST_IDLE);
      coef_wr_rej  <= coef_wr_en && !idle_s;
      result_valid <= (state_r == ST_CAPTURE);
      if (state_r == ST_CAPTURE) begin
        result_out <= sat_result(acc_shift_s);
      end
      if (sample_stb && !idle_s) begin
        overrun <= 1'b1;
      end
    end
  end

  // Sample history; the sample is committed on the cycle it is accepted
  fir_history_ram #(
    .DEPTH (NUM_TAPS),
    .WIDTH (SAMPLE_W)
  ) u_history (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_en     (accept_s),
    .wr_data   (sample_in),
    .rd_en     (hist_rd_s),
    .rd_offset (rd_k_s),
    .rd_data   (tap_data)
  );

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed bench for fir_tap_sequencer with a behavioural MAC tap model.
module tb_fir_tap_sequencer;

  localparam int N  = 64;
  localparam int PL = 7;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_stb;
  logic [23:0] sample_in;
  logic        coef_wr_en;
  logic [5:0]  coef_wr_addr;
  logic [15:0] coef_wr_data;
  logic        coef_wr_rej;
  logic        tap_clr;
  logic        tap_en;
  logic [15:0] tap_coef;
  logic [23:0] tap_data;
  logic [47:0] tap_acc;
  logic [23:0] result_out;
  logic        result_valid;
  logic        busy;
  logic        overrun;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_tap_sequencer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .sample_stb   (sample_stb),
    .sample_in    (sample_in),
    .coef_wr_en   (coef_wr_en),
    .coef_wr_addr (coef_wr_addr),
    .coef_wr_data (coef_wr_data),
    .coef_wr_rej  (coef_wr_rej),
    .tap_clr      (tap_clr),
    .tap_en       (tap_en),
    .tap_coef     (tap_coef),
    .tap_data     (tap_data),
    .tap_acc      (tap_acc),
    .result_out   (result_out),
    .result_valid (result_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  // Tap model: product truncated by 8 bits, accumulated, visible PL cycles later
  logic signed [47:0] acc_m = 48'sd0;
  logic [47:0] dly [PL-1] = '{default: 48'd0};

  function automatic logic signed [47:0] tap_product(input logic [23:0] d, input logic [15:0] c);
    logic signed [47:0] dx;
    logic signed [47:0] cx;
    dx = {{24{d[23]}}, d};
    cx = {{32{c[15]}}, c};
    return (dx * cx) >>> 8;
  endfunction

  // Tap accumulator followed by a delay line to model its pipeline depth
  always @(posedge clk) begin
    if (tap_clr) acc_m <= 48'sd0;
    else if (tap_en) acc_m <= acc_m + tap_product(tap_data, tap_coef);
    dly[0] <= acc_m;
    for (int i = 1; i < PL - 1; i++) dly[i] <= dly[i-1];
  end
  assign tap_acc = dly[PL-2];

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic load_coefs(input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] cr);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      coef_wr_en   = 1'b1;
      coef_wr_addr = 6'(i);
      coef_wr_data = (i == 0) ? c0 : ((i == 1) ? c1 : cr);
    end
    @(negedge clk);
    coef_wr_en = 1'b0;
  endtask

  task automatic wait_result(input int start, output logic [23:0] res, output int lat);
    lat = start;
    while (!result_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    res = result_out;
  endtask

  task automatic send_sample(input logic [23:0] v, output logic [23:0] res, output int lat);
    @(negedge clk);
    sample_stb = 1'b1;
    sample_in  = v;
    @(negedge clk);
    sample_stb = 1'b0;
    wait_result(1, res, lat);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    logic [23:0] res;
    int          lat;
    logic        seen;
    reset_n = 1'b0; sample_stb = 1'b0; sample_in = 24'd0;
    coef_wr_en = 1'b0; coef_wr_addr = 6'd0; coef_wr_data = 16'd0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {tap_clr, tap_en, busy, overrun, result_valid, coef_wr_rej}, 48'd0);
    check("reset_coef", tap_coef, 48'd0);
    check("reset_data", tap_data, 48'd0);
    check("reset_result", result_out, 48'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Impulse with cycle-level checks of the schedule
    load_coefs(16'h4000, 16'h0000, 16'h0000);
    check("idle_write_no_rej", coef_wr_rej, 48'd0);
    @(negedge clk);
    sample_stb = 1'b1; sample_in = 24'd1000;
    @(negedge clk);
    sample_stb = 1'b0;                                  // cycle 1: CLEAR
    check("clear_tap_clr", tap_clr, 48'd1);
    check("clear_tap_en", tap_en, 48'd0);
    check("clear_busy", busy, 48'd1);
    @(negedge clk);                                     // cycle 2: RUN k=0
    check("run0_tap_en", tap_en, 48'd1);
    check("run0_tap_coef", tap_coef, 48'h4000);
    check("run0_tap_data", tap_data, 48'd1000);
    @(negedge clk);                                     // cycle 3: k=1 beyond fill
    check("run1_unfilled_data", tap_data, 48'd0);
    wait_result(3, res, lat);
    check("impulse_latency", lat, 48'd74);
    check("impulse_result", res, 48'd500);
    @(negedge clk);
    check("valid_one_cycle", result_valid, 48'd0);
    check("result_held", result_out, 48'd500);
    check("idle_not_busy", busy, 48'd0);

    // Fill / accumulate from a fresh history
    do_reset();
    load_coefs(16'h2000, 16'h2000, 16'h2000);
    send_sample(24'd4000, res, lat);
    check("fill_first", res, 48'd1000);
    send_sample(24'd8000, res, lat);
    check("fill_second", res, 48'd3000);
    check("fill_latency", lat, 48'd74);

    // Positive then negative saturation
    load_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF);
    for (int i = 0; i < N; i++) send_sample(24'h7FFFFF, res, lat);
    check("sat_positive", res, 48'h7FFFFF);
    for (int i = 0; i < N; i++) send_sample(24'h800000, res, lat);
    check("sat_negative", res, 48'h800000);

    // Overrun: second strobe while busy is dropped
    do_reset();
    check("overrun_clear_after_reset", overrun, 48'd0);
    load_coefs(16'h4000, 16'h4000, 16'h0000);
    @(negedge clk);
    sample_stb = 1'b1; sample_in = 24'd1000;
    @(negedge clk);
    sample_stb = 1'b0;
    repeat (9) @(negedge clk);                          // cycle 10
    sample_stb = 1'b1; sample_in = 24'd3000;
    @(negedge clk);
    sample_stb = 1'b0;                                  // cycle 11
    check("overrun_flag", overrun, 48'd1);
    wait_result(11, res, lat);
    check("overrun_result", res, 48'd500);
    check("overrun_latency", lat, 48'd74);
    send_sample(24'd2000, res, lat);
    check("overrun_history_intact", res, 48'd1500);
    check("overrun_sticky", overrun, 48'd1);

    // Coefficient write during RUN is rejected
    @(negedge clk);
    sample_stb = 1'b1; sample_in = 24'd600;
    @(negedge clk);
    sample_stb = 1'b0;
    repeat (19) @(negedge clk);                         // cycle 20
    coef_wr_en = 1'b1; coef_wr_addr = 6'd0; coef_wr_data = 16'h7000;
    @(negedge clk);
    coef_wr_en = 1'b0;                                  // cycle 21
    check("busy_write_rej", coef_wr_rej, 48'd1);
    @(negedge clk);
    check("busy_write_rej_pulse", coef_wr_rej, 48'd0);
    wait_result(22, res, lat);
    check("busy_write_run_result", res, 48'd1300);
    send_sample(24'd1000, res, lat);
    check("busy_write_old_coef", res, 48'd800);

    // Reset in the middle of RUN
    @(negedge clk);
    sample_stb = 1'b1; sample_in = 24'd5000;
    @(negedge clk);
    sample_stb = 1'b0;
    repeat (19) @(negedge clk);                         // cycle 20
    reset_n = 1'b0;
    #1;
    check("midrst_ctrl", {tap_clr, tap_en, busy, overrun, result_valid, coef_wr_rej}, 48'd0);
    check("midrst_coef", tap_coef, 48'd0);
    check("midrst_data", tap_data, 48'd0);
    check("midrst_result", result_out, 48'd0);
    @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (result_valid) seen = 1'b1;
    end
    check("midrst_no_valid", seen, 48'd0);
    load_coefs(16'h4000, 16'h4000, 16'h0000);
    send_sample(24'd1000, res, lat);
    check("midrst_history_ignored", res, 48'd500);
    check("midrst_latency", lat, 48'd74);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
